// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: one outstanding imem read, a single-entry output register, redirect squashing and a wait timeout.
// Optional IF_MISALIGN_TRAP_EN makes a misaligned redirect target fatal instead of being aligned down.
module if_fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_out,
    output logic [63:0] pc_out,
    output logic        fetch_fault
);
    localparam int WW = $clog2(MAX_WAIT + 2);

    typedef enum logic [1:0] {IDLE, REQ, SQUASH, FAULT} state_t;

    state_t        state_q, state_d;
    logic [63:0]   pc_q, pc_d;
    logic [63:0]   addr_q, addr_d;
    logic [63:0]   pc_out_q, pc_out_d;
    logic [31:0]   instr_q, instr_d;
    logic          vld_q, vld_d;
    logic          fault_q, fault_d;
    logic [WW-1:0] wait_q, wait_d;

    logic [63:0]   redir_tgt;
    logic          redir_bad;
    logic          wait_over;

`ifdef IF_MISALIGN_TRAP_EN
    assign redir_tgt = redirect_pc;
    assign redir_bad = |redirect_pc[1:0];
`else
    logic unused_lsb;
    assign unused_lsb = ^redirect_pc[1:0];
    assign redir_tgt  = {redirect_pc[63:2], 2'b00};
    assign redir_bad  = 1'b0;
`endif

    // Timeout fires on the (MAX_WAIT+1)-th consecutive cycle without an ack.
    assign wait_over = (wait_q == WW'(MAX_WAIT));

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        pc_out_d = pc_out_q;
        instr_d  = instr_q;
        vld_d    = vld_q;
        fault_d  = fault_q;
        wait_d   = wait_q;

        if (vld_q && instr_ready) vld_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (redirect_valid) begin
                    vld_d = 1'b0;
                    pc_d  = redir_tgt;
                    if (redir_bad) begin
                        state_d = FAULT;
                        fault_d = 1'b1;
                    end
                end else if (!vld_q || instr_ready) begin
                    state_d = REQ;
                    addr_d  = pc_q;
                    wait_d  = '0;
                end
            end
            REQ, SQUASH: begin
                if (!imem_ack && wait_over) begin
                    state_d = FAULT;
                    fault_d = 1'b1;
                    vld_d   = 1'b0;
                end else begin
                    if (!imem_ack) wait_d = wait_q + 1'b1;
                    if (redirect_valid) begin
                        // The in-flight response (if not landing now) still has to be swallowed.
                        vld_d   = 1'b0;
                        pc_d    = redir_tgt;
                        state_d = imem_ack ? IDLE : SQUASH;
                        if (redir_bad) begin
                            state_d = FAULT;
                            fault_d = 1'b1;
                        end
                    end else if (imem_ack) begin
                        state_d = IDLE;
                        if (state_q == REQ) begin
                            instr_d  = imem_rdata;
                            pc_out_d = pc_q;
                            vld_d    = 1'b1;
                            pc_d     = pc_q + 64'd4;
                        end
                    end
                end
            end
            FAULT: begin
                vld_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            addr_q   <= RESET_PC;
            pc_out_q <= 64'h0;
            instr_q  <= 32'h0;
            vld_q    <= 1'b0;
            fault_q  <= 1'b0;
            wait_q   <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            pc_out_q <= pc_out_d;
            instr_q  <= instr_d;
            vld_q    <= vld_d;
            fault_q  <= fault_d;
            wait_q   <= wait_d;
        end
    end

    assign imem_req    = (state_q == REQ) || (state_q == SQUASH);
    assign imem_addr   = addr_q;
    assign instr_valid = vld_q;
    assign instr_out   = instr_q;
    assign pc_out      = pc_out_q;
    assign fetch_fault = fault_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus a randomized run, all hand-offs checked against an expected-PC stream model.
module tb_if_fetch_stage;
    localparam logic [63:0] RPC  = 64'h0;
    localparam int          MAXW = 15;

    logic        clk, reset;
    logic        imem_req, imem_ack;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        instr_valid, instr_ready;
    logic [31:0] instr_out;
    logic [63:0] pc_out;
    logic        fetch_fault;

    if_fetch_stage #(.RESET_PC(RPC), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_out(instr_out), .pc_out(pc_out),
        .fetch_fault(fetch_fault)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] f(input logic [63:0] a);
        return a[31:0] ^ {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Memory: auto responder with programmable latency, or manual drive from the main sequence.
    logic        auto_mode, r_ack, m_ack;
    logic [31:0] r_rdata, m_rdata;
    int          mem_lat, wcnt;
    assign imem_ack   = auto_mode ? r_ack   : m_ack;
    assign imem_rdata = auto_mode ? r_rdata : m_rdata;

    initial begin
        r_ack = 1'b0; r_rdata = 32'h0; wcnt = 0;
        forever begin
            @(negedge clk);
            r_ack = 1'b0;
            if (imem_req === 1'b1) begin
                if (wcnt >= mem_lat) begin
                    r_ack = 1'b1; r_rdata = f(imem_addr); wcnt = 0;
                end else wcnt++;
            end else wcnt = 0;
        end
    end

    typedef struct {
        int          kind;
        logic [63:0] pc;
        logic [31:0] ins;
    } ev_t;
    ev_t evq[$];
    int  ho_cyc[$];
    int  n_ho, cyc_n;

    // Event log: 0 = hand-off, 1 = redirect, 2 = reset; in the order they take effect at the next edge.
    initial begin
        n_ho = 0; cyc_n = 0;
        forever begin
            @(negedge clk); #1;
            cyc_n++;
            if (reset) evq.push_back('{2, 64'h0, 32'h0});
            else begin
                if (instr_valid && instr_ready) begin
                    evq.push_back('{0, pc_out, instr_out});
                    ho_cyc.push_back(cyc_n);
                    n_ho++;
                end
                if (redirect_valid) evq.push_back('{1, redirect_pc, 32'h0});
            end
        end
    end

    int          checks, errs;
    logic [63:0] exp_pc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_stream();
        ev_t e;
        while (evq.size() > 0) begin
            e = evq.pop_front();
            case (e.kind)
                0: begin
                    chk("stream_pc", e.pc, exp_pc);
                    chk("stream_ins", {32'h0, e.ins}, {32'h0, f(e.pc)});
                    exp_pc = e.pc + 64'd4;
                end
                1: exp_pc = {e.pc[63:2], 2'b00};
                default: exp_pc = RPC;
            endcase
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"}, imem_req, 0);
        chk({tag, "_vld"}, instr_valid, 0);
        chk({tag, "_ins"}, instr_out, 0);
        chk({tag, "_pco"}, pc_out, 0);
        chk({tag, "_flt"}, fetch_fault, 0);
    endtask

    initial begin
        logic [31:0] h_i;
        logic [63:0] h_p;
        bit          got;
        int          n0;
        checks = 0; errs = 0; exp_pc = RPC;
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 64'h0;
        instr_ready = 1'b1; auto_mode = 1'b1; mem_lat = 0;
        m_ack = 1'b0; m_rdata = 32'h0;

        // Reset state and first three sequential fetches.
        cyc(); cyc();
        chk_reset_vals("rst0");
        cyc(); reset = 1'b0;
        cyc();
        chk("first_req", imem_req, 1);
        chk("first_addr", imem_addr, RPC);
        for (int i = 0; i < 40 && n_ho < 3; i++) cyc();
        chk("three_fetched", n_ho >= 3, 1);
        if (ho_cyc.size() >= 3) begin
            chk("thru_gap1", 64'(ho_cyc[1] - ho_cyc[0]), 2);
            chk("thru_gap2", 64'(ho_cyc[2] - ho_cyc[1]), 2);
        end
        check_stream();

        // Back-pressure: output held, no request while stalled.
        cyc(); auto_mode = 1'b0; instr_ready = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(); m_ack = 1'b0;
            if (instr_valid && !imem_req) begin got = 1'b1; break; end
            if (imem_req) begin m_ack = 1'b1; m_rdata = f(imem_addr); end
        end
        chk("stall_valid", got, 1);
        h_i = instr_out; h_p = pc_out;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("stall_ins", instr_out, h_i);
            chk("stall_pc", pc_out, h_p);
            chk("stall_noreq", imem_req, 0);
        end
        instr_ready = 1'b1;
        cyc();
        chk("resume_addr", imem_addr, h_p + 64'd4);
        chk("resume_req", imem_req, 1);

        // Redirect while awaiting ack; the late response must be swallowed.
        redirect_valid = 1'b1; redirect_pc = 64'h100;
        cyc(); redirect_valid = 1'b0;
        chk("sq_req", imem_req, 1);
        chk("sq_vld", instr_valid, 0);
        cyc(); m_ack = 1'b1; m_rdata = 32'hDEAD_BEEF;
        cyc(); m_ack = 1'b0;
        chk("sq_drop_vld", instr_valid, 0);
        chk("sq_idle", imem_req, 0);
        cyc();
        chk("sq_next_req", imem_req, 1);
        chk("sq_next_addr", imem_addr, 64'h100);
        m_ack = 1'b1; m_rdata = f(64'h100);
        cyc(); m_ack = 1'b0;
        chk("sq_tgt_vld", instr_valid, 1);
        chk("sq_tgt_pc", pc_out, 64'h100);
        chk("sq_not_dead", instr_out == 32'hDEAD_BEEF, 0);

        // Redirect coincident with ack.
        cyc();
        chk("co_addr0", imem_addr, 64'h104);
        m_ack = 1'b1; m_rdata = 32'hBAD0_BAD0;
        redirect_valid = 1'b1; redirect_pc = 64'h200;
        cyc(); m_ack = 1'b0; redirect_valid = 1'b0;
        chk("co_vld", instr_valid, 0);
        chk("co_idle", imem_req, 0);
        cyc();
        chk("co_req", imem_req, 1);
        chk("co_addr", imem_addr, 64'h200);
        m_ack = 1'b1; m_rdata = f(64'h200);
        cyc(); m_ack = 1'b0;
        chk("co_pc", pc_out, 64'h200);

        // Misaligned redirect target.
        cyc();
        redirect_valid = 1'b1; redirect_pc = 64'h102;
        cyc(); redirect_valid = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
        chk("mis_fault", fetch_fault, 1);
        chk("mis_noreq", imem_req, 0);
        chk("mis_vld", instr_valid, 0);
`else
        chk("mis_nofault", fetch_fault, 0);
        m_ack = 1'b1; m_rdata = 32'hDEAD_BEEF;
        cyc(); m_ack = 1'b0;
        cyc();
        chk("mis_req", imem_req, 1);
        chk("mis_addr", imem_addr, 64'h100);
        m_ack = 1'b1; m_rdata = f(64'h100);
        cyc(); m_ack = 1'b0;
        chk("mis_pc", pc_out, 64'h100);
        cyc();
`endif

        // Reset mid-request, with redirect/ack present; ack right after reset ignored.
        reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h300;
        m_ack = 1'b1; m_rdata = 32'h1111_1111;
        cyc();
        chk_reset_vals("rst1");
        reset = 1'b0; redirect_valid = 1'b0; m_ack = 1'b1; m_rdata = 32'h2222_2222;
        cyc(); m_ack = 1'b0;
        chk("rst_ack_ign", instr_valid, 0);
        chk("rst_req", imem_req, 1);
        chk("rst_addr", imem_addr, RPC);
        check_stream();

        // Timeout: fault exactly after MAX_WAIT+1 ack-less cycles, then sticky.
        for (int i = 0; i < MAXW; i++) begin
            cyc();
            chk("to_early", fetch_fault, 0);
        end
        cyc();
        chk("to_fault", fetch_fault, 1);
        chk("to_noreq", imem_req, 0);
        redirect_valid = 1'b1; redirect_pc = 64'h300; m_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("flt_sticky", fetch_fault, 1);
            chk("flt_noreq", imem_req, 0);
            chk("flt_vld", instr_valid, 0);
        end
        redirect_valid = 1'b0; m_ack = 1'b0;

        // Randomized run against the stream model.
        reset = 1'b1;
        cyc(); cyc();
        check_stream();
        n0 = n_ho;
        auto_mode = 1'b1; mem_lat = $urandom_range(0, 5);
        reset = 1'b0;
        for (int i = 0; i < 600; i++) begin
            cyc();
            if (i % 150 == 0) mem_lat = $urandom_range(0, 5);
            instr_ready    = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
`ifdef IF_MISALIGN_TRAP_EN
            redirect_pc    = {52'h0, 10'($urandom_range(0, 1023)), 2'b00};
`else
            redirect_pc    = {52'h0, 12'($urandom_range(0, 4095))};
`endif
        end
        redirect_valid = 1'b0; instr_ready = 1'b1;
        for (int i = 0; i < 30; i++) cyc();
        check_stream();
        chk("rnd_nofault", fetch_fault, 0);
        chk("rnd_progress", (n_ho - n0) >= 50, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 64'h0, address of the first fetch after reset.
REQ-002 Parameter MAX_WAIT, default 15, imem wait-cycle limit before a timeout fault.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_req  output  1  instruction memory read request.
REQ-006 imem_addr  output  64  byte address of the requested instruction word.
REQ-007 imem_ack  input  1  memory response valid, sampled on a rising edge.
REQ-008 imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-009 redirect_valid  input  1  branch/jump redirect from execute.
REQ-010 redirect_pc  input  64  redirect target address.
REQ-011 instr_valid  output  1  instr_out/pc_out hold a valid instruction.
REQ-012 instr_ready  input  1  decode accepts the instruction this cycle.
REQ-013 instr_out  output  32  fetched instruction word.
REQ-014 pc_out  output  64  address of instr_out.
REQ-015 fetch_fault  output  1  sticky fault flag: timeout, or misaligned target when the option is compiled in.

Function
REQ-016 FSM states SHALL be IDLE, REQ (request outstanding), SQUASH (outstanding response to discard), FAULT.
REQ-017 IDLE->REQ SHALL occur when the output register is empty or is being drained this cycle (instr_valid&&instr_ready); imem_req=1 and imem_addr=pc in REQ and SQUASH.
REQ-018 imem_addr SHALL stay stable while imem_req=1 until imem_ack is sampled.
REQ-019 On ack in REQ: instr_out<=imem_rdata, pc_out<=pc, instr_valid<=1, pc<=pc+4 (modulo 2^64), next state IDLE.
REQ-020 Hand-off SHALL occur only on instr_valid&&instr_ready; instr_valid clears the following cycle unless a new ack lands in that same cycle.
REQ-021 While instr_valid=1 and instr_ready=0, instr_out/pc_out SHALL hold and no new request SHALL issue.
REQ-022 Best-case throughput SHALL be one instruction per two cycles (request cycle, ack cycle); fetch latency from request to instr_valid is the ack delay plus one cycle.
REQ-023 redirect_valid SHALL set pc<=redirect_pc and clear instr_valid on the next edge in any non-FAULT state.
REQ-024 Redirect while in REQ without ack SHALL enter SQUASH; the next ack is discarded, then pc (the target) is requested from IDLE.
REQ-025 Redirect and ack in the same cycle: redirect wins, rdata discarded, next state IDLE.
REQ-026 A wait counter SHALL count cycles in REQ/SQUASH without ack; exceeding MAX_WAIT SHALL set fetch_fault=1 and enter FAULT.
REQ-027 FAULT SHALL hold imem_req=0 and instr_valid=0 and ignore redirect until reset.

Reset
REQ-028 Reset SHALL force state IDLE, pc=RESET_PC, imem_req=0, instr_valid=0, instr_out=32'h0, pc_out=64'h0, fetch_fault=0, wait counter=0.
REQ-029 Reset mid-request SHALL abandon the outstanding request; an ack in the first cycle after reset SHALL be ignored.
REQ-030 Reset SHALL take priority over redirect, ack and instr_ready.

Configuration
REQ-031 Macro IF_MISALIGN_TRAP_EN: when defined, a redirect_pc with bits[1:0]!=0 SHALL set fetch_fault=1 and enter FAULT without issuing a request.
REQ-032 Without IF_MISALIGN_TRAP_EN, redirect_pc[1:0] SHALL be forced to 2'b00 and fetching continues normally.

Verification
REQ-033 Reset released at 25 ns, ack one cycle after each req, instr_ready=1 -> addresses 0x0,0x4,0x8 fetched; pc_out matches each instr_out.
REQ-034 instr_ready=0 for 5 cycles with instr_valid=1 -> instr_out/pc_out stable, imem_req=0 throughout.
REQ-035 Redirect to 0x100 while awaiting ack, ack 2 cycles later with 0xDEADBEEF -> 0xDEADBEEF never presented; next request address 0x100.
REQ-036 Redirect to 0x200 coincident with ack -> rdata dropped, next imem_addr=0x200.
REQ-037 No ack for MAX_WAIT+1 cycles -> fetch_fault=1, imem_req=0 until reset.
REQ-038 Redirect to 0x102: with IF_MISALIGN_TRAP_EN fetch_fault=1; without it next imem_addr=0x100.
